// File: rtl/stream_upsizer_pkg.sv
// stream_upsizer_pkg: shared valid/ready stream conventions for narrow-to-wide packing.
// Lane k of a packed word holds beat k; keep bit k marks lane k as carrying data.
// A word's lanes always fill from lane 0 upward, so keep masks are contiguous from bit 0.
package stream_upsizer_pkg;
  localparam int LANE_MAX = 32;
  function automatic logic [LANE_MAX-1:0] keep_mask(input int unsigned n);
    logic [LANE_MAX-1:0] one;
    one = LANE_MAX'(1);
    return (one << (n + 1)) - one;
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: single-register valid/ready pipeline stage that feeds stream_upsizer.
// Ports:
//   clk, i_reset_n            clock, asynchronous active-low reset
//   i_data, i_vld, o_rdy      upstream beat, valid, ready
//   o_data, o_vld, i_rdy      downstream beat, valid, ready
// The register refills whenever it is empty or being drained, giving one beat per cycle.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_data,
  input  logic         i_vld,
  output logic         o_rdy,
  output logic [W-1:0] o_data,
  output logic         o_vld,
  input  logic         i_rdy
);
  assign o_rdy = !o_vld || i_rdy;
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_vld  <= 1'b0;
      o_data <= '0;
    end else if (o_rdy) begin
      o_vld <= i_vld;
      if (i_vld) o_data <= i_data;
    end
  end
endmodule

// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO narrow valid/ready beats into one wide word.
// Ports:
//   clk, i_reset_n            clock, asynchronous active-low reset
//   i_data, i_last, i_vld     input beat, end-of-packet marker, valid
//   o_rdy                     beat accepted this cycle (registered, no input path)
//   o_data, o_keep, o_last    packed word, lane-valid mask, end-of-packet
//   o_vld, i_rdy              output valid, downstream ready
// A completed word goes straight to the output registers when they are free or
// draining; otherwise it parks in the accumulator and input stalls until it moves.
module stream_upsizer
  import stream_upsizer_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      i_reset_n,
  input  logic [IN_WIDTH-1:0]       i_data,
  input  logic                      i_last,
  input  logic                      i_vld,
  output logic                      o_rdy,
  output logic [IN_WIDTH*RATIO-1:0] o_data,
  output logic [RATIO-1:0]          o_keep,
  output logic                      o_last,
  output logic                      o_vld,
  input  logic                      i_rdy
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = $clog2(RATIO);
  logic [CNT_W-1:0]     cnt;
  logic [OUT_WIDTH-1:0] acc, w_data;
  logic [RATIO-1:0]     acc_keep, w_keep;
  logic                 acc_last, acc_full, wr, done, can_load;
  assign o_rdy    = !acc_full;
  assign wr       = i_vld && o_rdy;
  assign done     = wr && (cnt == CNT_W'(RATIO - 1) || i_last);
  assign can_load = !o_vld || i_rdy;
  // Lanes at and above cnt are still zero, so OR-ing the new beat in is enough.
  assign w_data   = acc | (OUT_WIDTH'(i_data) << (cnt * IN_WIDTH));
  assign w_keep   = RATIO'(keep_mask(32'(cnt)));
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt      <= '0;
      acc      <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      acc_full <= 1'b0;
      o_data   <= '0;
      o_keep   <= '0;
      o_last   <= 1'b0;
      o_vld    <= 1'b0;
    end else if (acc_full) begin
      if (can_load) begin
        o_data   <= acc;
        o_keep   <= acc_keep;
        o_last   <= acc_last;
        o_vld    <= 1'b1;
        acc      <= '0;
        acc_keep <= '0;
        acc_full <= 1'b0;
      end
    end else if (done) begin
      cnt <= '0;
      if (can_load) begin
        o_data   <= w_data;
        o_keep   <= w_keep;
        o_last   <= i_last;
        o_vld    <= 1'b1;
        acc      <= '0;
        acc_keep <= '0;
      end else begin
        acc      <= w_data;
        acc_keep <= w_keep;
        acc_last <= i_last;
        acc_full <= 1'b1;
      end
    end else begin
      if (wr) begin
        acc      <= w_data;
        acc_keep <= w_keep;
        cnt      <= cnt + 1'b1;
      end
      if (i_rdy) o_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_upsizer.sv
// tb_stream_upsizer: directed and randomized checks of stream_upsizer, optionally fed through pipe_stage.
module tb_stream_upsizer;
  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;
  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [7:0]  tb_data = '0;
  logic        tb_last = 1'b0, tb_vld = 1'b0;
  logic        use_pipe = 1'b0, up_i_rdy = 1'b1, rnd_rdy = 1'b0, mon_en = 1'b0;
  logic [8:0]  ps_data;
  logic        ps_vld, ps_rdy;
  logic [7:0]  up_data;
  logic        up_last, up_vld, up_rdy, sys_rdy;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_last, o_vld;
  int          n_cmp = 0, n_err = 0;
  word_t       exp_q[$];
  logic [7:0]  part[$];
  logic        stalled = 1'b0;
  word_t       held, got;
  always #5 clk = ~clk;
  pipe_stage #(.W(9)) u_ps (
    .clk(clk), .i_reset_n(i_reset_n), .i_data({tb_last, tb_data}), .i_vld(use_pipe && tb_vld),
    .o_rdy(ps_rdy), .o_data(ps_data), .o_vld(ps_vld), .i_rdy(up_rdy)
  );
  assign up_data = use_pipe ? ps_data[7:0] : tb_data;
  assign up_last = use_pipe ? ps_data[8] : tb_last;
  assign up_vld  = use_pipe ? ps_vld : tb_vld;
  assign sys_rdy = use_pipe ? ps_rdy : up_rdy;
  stream_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_data(up_data), .i_last(up_last), .i_vld(up_vld),
    .o_rdy(up_rdy), .o_data(o_data), .o_keep(o_keep), .o_last(o_last), .o_vld(o_vld), .i_rdy(up_i_rdy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    tb_data = d;
    tb_last = l;
    tb_vld  = 1'b1;
    @(negedge clk);
    while (!sys_rdy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("send_timeout", 64'(n), 0);
    @(posedge clk);
    #1;
    tb_vld = 1'b0;
  endtask
  // Reference model: beats accepted at the system input are grouped into words of
  // up to four (closed early by last); output transfers must match in order.
  always @(negedge clk) begin
    if (mon_en) begin
      got = {o_data, o_keep, o_last};
      if (o_vld && up_i_rdy) begin
        chk("word_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("word", 64'(got), 64'(exp_q.pop_front()));
      end
      if (stalled) begin
        chk("stall_vld", 64'(o_vld), 1);
        chk("stall_word", 64'(got), 64'(held));
      end
      stalled = o_vld && !up_i_rdy;
      held = got;
      if (tb_vld && sys_rdy) begin
        part.push_back(tb_data);
        if (part.size() == 4 || tb_last) begin
          word_t w;
          w.d = '0;
          foreach (part[k]) w.d |= 32'(part[k]) << (8 * k);
          w.k = 4'((1 << part.size()) - 1);
          w.l = tb_last;
          exp_q.push_back(w);
          part.delete();
        end
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (rnd_rdy) up_i_rdy = ($urandom % 3) != 0;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    cyc(1);
    chk("rst_vld", 64'(o_vld), 0);
    chk("rst_rdy", 64'(up_rdy), 1);
    chk("rst_data", 64'(o_data), 0);
    chk("rst_keep", 64'(o_keep), 0);
    chk("rst_last", 64'(o_last), 0);
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    chk("full_vld_early", 64'(o_vld), 0);
    send(8'h44, 0);
    chk("full_data", 64'(o_data), 64'h44332211);
    chk("full_keep", 64'(o_keep), 64'hf);
    chk("full_last", 64'(o_last), 0);
    chk("full_vld", 64'(o_vld), 1);
    chk("full_rdy", 64'(up_rdy), 1);
    cyc(1);
    chk("full_drain", 64'(o_vld), 0);
    send(8'hAA, 0);
    send(8'hBB, 1);
    chk("part_data", 64'(o_data), 64'h0000BBAA);
    chk("part_keep", 64'(o_keep), 64'h3);
    chk("part_last", 64'(o_last), 1);
    send(8'hCC, 1);
    chk("first_last_data", 64'(o_data), 64'h000000CC);
    chk("first_last_keep", 64'(o_keep), 64'h1);
    chk("first_last_last", 64'(o_last), 1);
    cyc(1);
    up_i_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    chk("bp_rdy_low", 64'(up_rdy), 0);
    chk("bp_vld", 64'(o_vld), 1);
    chk("bp_data", 64'(o_data), 64'h04030201);
    cyc(3);
    chk("bp_hold_data", 64'(o_data), 64'h04030201);
    chk("bp_hold_rdy", 64'(up_rdy), 0);
    up_i_rdy = 1'b1;
    cyc(1);
    chk("bp_second_data", 64'(o_data), 64'h08070605);
    chk("bp_second_vld", 64'(o_vld), 1);
    chk("bp_rdy_back", 64'(up_rdy), 1);
    cyc(1);
    chk("bp_empty", 64'(o_vld), 0);
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h40 + i), 0);
      chk("stream_rdy", 64'(up_rdy), 1);
      chk("stream_vld", 64'(o_vld), 64'(i % 4 == 3));
    end
    cyc(1);
    send(8'h01, 0);
    send(8'h02, 0);
    #3;
    mon_en = 1'b0;
    i_reset_n = 1'b0;
    #1;
    chk("arst_vld", 64'(o_vld), 0);
    chk("arst_rdy", 64'(up_rdy), 1);
    chk("arst_keep", 64'(o_keep), 0);
    part.delete();
    exp_q.delete();
    stalled = 1'b0;
    @(posedge clk);
    #2;
    i_reset_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'(8'hA0 + i), 0);
    chk("post_rst_data", 64'(o_data), 64'hA4A3A2A1);
    chk("post_rst_keep", 64'(o_keep), 64'hf);
    chk("post_rst_last", 64'(o_last), 0);
    cyc(2);
    use_pipe = 1'b1;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      cyc($urandom_range(0, 2));
      send(8'($urandom), ($urandom % 6) == 0);
    end
    send(8'h5A, 1);
    rnd_rdy = 1'b0;
    up_i_rdy = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || o_vld || ps_vld) && n < 500) begin
      n++;
      cyc(1);
    end
    chk("drain_words", 64'(exp_q.size()), 0);
    chk("drain_beats", 64'(part.size()), 0);
    chk("drain_vld", 64'(o_vld), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
